// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control/datapath signal bundle for multicycle_control
// illegal_instruction exists only when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_if #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int WB_SEL_WIDTH = 3
);
  logic [6:0]              inst_opcode;
  logic                    inst_mem_ready;
  logic                    data_mem_ready;
  logic                    inst_mem_read_enable;
  logic                    ir_write_enable;
  logic                    pc_write_enable;
  logic                    regfile_write_enable;
  logic                    jal_enable;
  logic                    jalr_enable;
  logic                    branch_enable;
  logic                    data_mem_read_enable;
  logic                    data_mem_write_enable;
  logic                    alu_operand_a_select;
  logic                    alu_operand_b_select;
  logic [ALU_OP_WIDTH-1:0] alu_op_type;
  logic [WB_SEL_WIDTH-1:0] reg_writeback_select;
  logic                    inst_retired;
  logic [2:0]              state;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic                    illegal_instruction;
`endif

  modport master (
    input  inst_opcode, inst_mem_ready, data_mem_ready,
    output inst_mem_read_enable, ir_write_enable, pc_write_enable,
           regfile_write_enable, jal_enable, jalr_enable, branch_enable,
           data_mem_read_enable, data_mem_write_enable,
           alu_operand_a_select, alu_operand_b_select, alu_op_type,
           reg_writeback_select, inst_retired, state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
           , illegal_instruction
`endif
  );

  modport slave (
    output inst_opcode, inst_mem_ready, data_mem_ready,
    input  inst_mem_read_enable, ir_write_enable, pc_write_enable,
           regfile_write_enable, jal_enable, jalr_enable, branch_enable,
           data_mem_read_enable, data_mem_write_enable,
           alu_operand_a_select, alu_operand_b_select, alu_op_type,
           reg_writeback_select, inst_retired, state
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
           , illegal_instruction
`endif
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP)
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of retiring them as NOPs.
module multicycle_control #(
  parameter int ALU_OP_WIDTH = 3,
  parameter int WB_SEL_WIDTH = 3
) (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master ctl
);
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

  localparam logic CTL_ALU_A_RS1 = 1'b0;
  localparam logic CTL_ALU_A_PC  = 1'b1;
  localparam logic CTL_ALU_B_RS2 = 1'b0;
  localparam logic CTL_ALU_B_IMM = 1'b1;

  localparam logic [ALU_OP_WIDTH-1:0] CTL_ALU_ZERO   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] CTL_ALU_ADD    = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] CTL_ALU_OP_IMM = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] CTL_ALU_OP     = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] CTL_ALU_BRANCH = ALU_OP_WIDTH'(4);

  localparam logic [WB_SEL_WIDTH-1:0] CTL_WRITEBACK_ALU  = WB_SEL_WIDTH'(0);
  localparam logic [WB_SEL_WIDTH-1:0] CTL_WRITEBACK_DATA = WB_SEL_WIDTH'(1);
  localparam logic [WB_SEL_WIDTH-1:0] CTL_WRITEBACK_PC4  = WB_SEL_WIDTH'(2);
  localparam logic [WB_SEL_WIDTH-1:0] CTL_WRITEBACK_IMM  = WB_SEL_WIDTH'(3);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic                    dec_legal;
  logic                    dec_a_sel;
  logic                    dec_b_sel;
  logic [ALU_OP_WIDTH-1:0] dec_alu_op;

  // Per-opcode ALU operand/op selection, shared by EXECUTE, MEM and WRITEBACK.
  always_comb begin
    dec_legal  = 1'b1;
    dec_a_sel  = CTL_ALU_A_RS1;
    dec_b_sel  = CTL_ALU_B_RS2;
    dec_alu_op = CTL_ALU_ZERO;
    case (ctl.inst_opcode)
      OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: begin
        dec_b_sel  = CTL_ALU_B_IMM;
        dec_alu_op = CTL_ALU_ADD;
      end
      OPCODE_OP_IMM: begin
        dec_b_sel  = CTL_ALU_B_IMM;
        dec_alu_op = CTL_ALU_OP_IMM;
      end
      OPCODE_AUIPC, OPCODE_JAL: begin
        dec_a_sel  = CTL_ALU_A_PC;
        dec_b_sel  = CTL_ALU_B_IMM;
        dec_alu_op = CTL_ALU_ADD;
      end
      OPCODE_OP:       dec_alu_op = CTL_ALU_OP;
      OPCODE_BRANCH:   dec_alu_op = CTL_ALU_BRANCH;
      OPCODE_LUI, OPCODE_MISC_MEM: dec_alu_op = CTL_ALU_ZERO;
      default:         dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d                   = state_q;
    ctl.inst_mem_read_enable  = 1'b0;
    ctl.ir_write_enable       = 1'b0;
    ctl.pc_write_enable       = 1'b0;
    ctl.regfile_write_enable  = 1'b0;
    ctl.jal_enable            = 1'b0;
    ctl.jalr_enable           = 1'b0;
    ctl.branch_enable         = 1'b0;
    ctl.data_mem_read_enable  = 1'b0;
    ctl.data_mem_write_enable = 1'b0;
    ctl.alu_operand_a_select  = CTL_ALU_A_RS1;
    ctl.alu_operand_b_select  = CTL_ALU_B_RS2;
    ctl.alu_op_type           = CTL_ALU_ZERO;
    ctl.reg_writeback_select  = CTL_WRITEBACK_ALU;
    ctl.inst_retired          = 1'b0;

    case (state_q)
      FETCH: begin
        ctl.inst_mem_read_enable = 1'b1;
        if (ctl.inst_mem_ready) begin
          ctl.ir_write_enable = 1'b1;
          state_d             = DECODE;
        end
      end
      DECODE: begin
        if (ctl.inst_opcode == OPCODE_MISC_MEM) begin
          ctl.pc_write_enable = 1'b1;
          ctl.inst_retired    = 1'b1;
          state_d             = FETCH;
        end else if (dec_legal) begin
          state_d = EXECUTE;
        end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          ctl.pc_write_enable = 1'b1;
          ctl.inst_retired    = 1'b1;
          state_d             = FETCH;
`endif
        end
      end
      EXECUTE: begin
        ctl.alu_operand_a_select = dec_a_sel;
        ctl.alu_operand_b_select = dec_b_sel;
        ctl.alu_op_type          = dec_alu_op;
        if (ctl.inst_opcode == OPCODE_LOAD || ctl.inst_opcode == OPCODE_STORE) begin
          state_d = MEM;
        end else if (ctl.inst_opcode == OPCODE_BRANCH) begin
          ctl.branch_enable   = 1'b1;
          ctl.pc_write_enable = 1'b1;
          ctl.inst_retired    = 1'b1;
          state_d             = FETCH;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEM: begin
        ctl.alu_operand_a_select  = dec_a_sel;
        ctl.alu_operand_b_select  = dec_b_sel;
        ctl.alu_op_type           = dec_alu_op;
        ctl.data_mem_read_enable  = (ctl.inst_opcode == OPCODE_LOAD);
        ctl.data_mem_write_enable = (ctl.inst_opcode == OPCODE_STORE);
        if (ctl.data_mem_ready) begin
          if (ctl.inst_opcode == OPCODE_STORE) begin
            ctl.pc_write_enable = 1'b1;
            ctl.inst_retired    = 1'b1;
            state_d             = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        ctl.alu_operand_a_select = dec_a_sel;
        ctl.alu_operand_b_select = dec_b_sel;
        ctl.alu_op_type          = dec_alu_op;
        ctl.regfile_write_enable = 1'b1;
        ctl.pc_write_enable      = 1'b1;
        ctl.inst_retired         = 1'b1;
        ctl.jal_enable           = (ctl.inst_opcode == OPCODE_JAL);
        ctl.jalr_enable          = (ctl.inst_opcode == OPCODE_JALR);
        case (ctl.inst_opcode)
          OPCODE_LOAD:             ctl.reg_writeback_select = CTL_WRITEBACK_DATA;
          OPCODE_JAL, OPCODE_JALR: ctl.reg_writeback_select = CTL_WRITEBACK_PC4;
          OPCODE_LUI:              ctl.reg_writeback_select = CTL_WRITEBACK_IMM;
          default:                 ctl.reg_writeback_select = CTL_WRITEBACK_ALU;
        endcase
        state_d = FETCH;
      end
      TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        state_d = TRAP;
`else
        state_d = FETCH;
`endif
      end
      default: state_d = FETCH;
    endcase

    // Reset overrides every side effect, even mid-access.
    if (reset) begin
      ctl.inst_mem_read_enable  = 1'b0;
      ctl.ir_write_enable       = 1'b0;
      ctl.pc_write_enable       = 1'b0;
      ctl.regfile_write_enable  = 1'b0;
      ctl.jal_enable            = 1'b0;
      ctl.jalr_enable           = 1'b0;
      ctl.branch_enable         = 1'b0;
      ctl.data_mem_read_enable  = 1'b0;
      ctl.data_mem_write_enable = 1'b0;
      ctl.inst_retired          = 1'b0;
    end
  end

  assign ctl.state = state_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign ctl.illegal_instruction = (state_q == TRAP);
`endif
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL provide parameter ALU_OP_WIDTH, default 3, width of alu_op_type.
REQ-003 SHALL provide parameter WB_SEL_WIDTH, default 3, width of reg_writeback_select.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 inst_opcode  input  7  opcode field of the instruction register, valid from DECODE onward.
REQ-007 inst_mem_ready  input  1  instruction fetch complete this cycle.
REQ-008 data_mem_ready  input  1  data access complete this cycle.
REQ-009 inst_mem_read_enable, ir_write_enable, pc_write_enable, regfile_write_enable, jal_enable, jalr_enable, branch_enable, data_mem_read_enable, data_mem_write_enable, alu_operand_a_select, alu_operand_b_select  output  1 each  datapath controls.
REQ-010 alu_op_type  output  ALU_OP_WIDTH;  reg_writeback_select  output  WB_SEL_WIDTH.
REQ-011 inst_retired  output  1  one-cycle pulse per completed instruction.
REQ-012 state  output  3  current FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.

Function
REQ-013 Outputs SHALL be combinational in state, inst_opcode and ready inputs. Defaults: all enables 0, selects CTL_ALU_A_RS1/CTL_ALU_B_RS2, alu_op_type CTL_ALU_ZERO, writeback CTL_WRITEBACK_ALU.
REQ-014 FETCH: inst_mem_read_enable=1. When inst_mem_ready=1: ir_write_enable=1, next DECODE; otherwise stay in FETCH, unbounded wait.
REQ-015 DECODE: OPCODE_MISC_MEM -> pc_write_enable=1, inst_retired=1, next FETCH. Any other legal opcode -> EXECUTE. Illegal opcode handled per REQ-024.
REQ-016 EXECUTE, MEM and WRITEBACK SHALL drive the per-opcode ALU selects and op of the single-cycle control table: LOAD/STORE/JALR = RS1, IMM, ADD; OP_IMM = RS1, IMM, OP_IMM; AUIPC/JAL = PC, IMM, ADD; OP = RS1, RS2, OP; LUI = ZERO; BRANCH = RS1, RS2, BRANCH.
REQ-017 EXECUTE transitions: LOAD/STORE -> MEM. BRANCH -> branch_enable=1, pc_write_enable=1, inst_retired=1, next FETCH. All other opcodes -> WRITEBACK.
REQ-018 MEM: data_mem_read_enable (LOAD) or data_mem_write_enable (STORE) SHALL be held until data_mem_ready=1. On ready, STORE -> pc_write_enable=1, inst_retired=1, next FETCH; LOAD -> WRITEBACK.
REQ-019 WRITEBACK: regfile_write_enable=1, pc_write_enable=1, inst_retired=1, next FETCH. Writeback select: DATA for LOAD, PC4 for JAL/JALR, IMM for LUI, ALU otherwise. jal_enable/jalr_enable SHALL be asserted for JAL/JALR.
REQ-020 With zero-wait memory, latency in cycles SHALL be: fence 2, branch 3, store 4, ALU/LUI/AUIPC/jump 4, load 5. Each ready-low cycle adds exactly one cycle.
REQ-021 inst_retired and pc_write_enable SHALL be asserted exactly once per instruction.

Reset
REQ-022 With reset=1 at a rising edge, state SHALL become FETCH, including from MEM mid-access, from WRITEBACK, or from TRAP.
REQ-023 While reset=1, all enable outputs and inst_retired SHALL be forced to 0, and state SHALL read 0 after the edge.

Configuration
REQ-024 Macro MULTICYCLE_ILLEGAL_TRAP_EN:
- Defined: an illegal opcode in DECODE SHALL go to TRAP. TRAP asserts output illegal_instruction=1, drives all enables 0 and holds until reset.
- Undefined: port illegal_instruction SHALL be absent. An illegal opcode SHALL retire as a NOP in DECODE: pc_write_enable=1, inst_retired=1, next FETCH.

Verification
REQ-025 OP_IMM, both ready inputs tied 1 -> states 0,1,2,4,0. regfile_write_enable=1 only in state 4; inst_retired=1 once.
REQ-026 LOAD with data_mem_ready low for 3 MEM cycles -> data_mem_read_enable high 4 cycles, then WRITEBACK with select DATA. Total 8 cycles.
REQ-027 BRANCH -> branch_enable=1 and pc_write_enable=1 in EXECUTE only. Total 3 cycles; regfile_write_enable never 1.
REQ-028 STORE with reset=1 asserted during the 2nd MEM wait cycle -> data_mem_write_enable=0 during reset, state=0 after the edge, no inst_retired pulse.
REQ-029 Opcode 7'b0000000 -> with macro defined: state=5, illegal_instruction=1, stays 5 for 10 cycles. Without macro: 2-cycle NOP with inst_retired=1.
